// File: rtl/autoconfig_master.sv
// rtl/autoconfig_master.sv - Zorro II autoconfig probe/configure bus master
// Build option: define AUTOCONFIG_SHUTUP_EN to shut up 8MB boards (size code 000)
// with a single $E8004C write instead of assigning them a base address.

module autoconfig_master #(
   parameter int unsigned WAIT_CLKS = 4,
   parameter logic [7:0]  BASE_HI   = 8'h20
) (
   input  logic        cpu_clk,
   input  logic        cpu_nreset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [22:0] cpu_a,
   output logic        cpu_nas,
   output logic        cpu_nuds,
   output logic        cpu_nlds,
   output logic        cpu_rnw,
   output logic [3:0]  cpu_d_out,
   output logic        cpu_d_oe,
   input  logic [3:0]  cpu_d_in,
   output logic [7:0]  cfg_type,
   output logic [7:0]  cfg_product,
   output logic [15:0] cfg_manuf,
   output logic        cfg_valid,
   output logic        cfg_absent
);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RELEASE, GAP} state_t;

   // HOLD exit counts: a read samples on the clock before release; a write
   // spends its first HOLD clock lowering cpu_nuds, then holds WAIT_CLKS.
   localparam logic [3:0] READ_LAST  = 4'(WAIT_CLKS - 2);
   localparam logic [3:0] WRITE_LAST = 4'(WAIT_CLKS - 1);

   state_t      state, state_nxt;
   logic [3:0]  step, step_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        armed;
   logic        busy_nxt, done_nxt;
   logic [22:0] cpu_a_nxt;
   logic        nas_nxt, nuds_nxt, nlds_nxt, rnw_nxt;
   logic [3:0]  d_out_nxt;
   logic        d_oe_nxt;
   logic [7:0]  type_nxt, product_nxt;
   logic [15:0] manuf_nxt;
   logic        valid_nxt, absent_nxt;

   logic        shut;
   logic        step_write;
   logic        last_step;
   logic [6:0]  step_woff;
   logic [3:0]  step_wdata;

`ifdef AUTOCONFIG_SHUTUP_EN
   assign shut = (cfg_type[2:0] == 3'b000);
`else
   assign shut = 1'b0;
`endif

   // Steps 0..7 are the register reads, 8 and 9 the base-address writes.
   assign step_write = step[3];
   assign last_step  = (step == 4'd9) || ((step == 4'd8) && shut);
   assign step_wdata = (step == 4'd8) ? (shut ? 4'h0 : BASE_HI[3:0]) : BASE_HI[7:4];

   // Word offset (A7..A1) inside the $E80000 autoconfig window for each step.
   always_comb begin
      step_woff = 7'h24;
      case (step)
         4'd0:    step_woff = 7'h00;
         4'd1:    step_woff = 7'h01;
         4'd2:    step_woff = 7'h02;
         4'd3:    step_woff = 7'h03;
         4'd4:    step_woff = 7'h08;
         4'd5:    step_woff = 7'h09;
         4'd6:    step_woff = 7'h0A;
         4'd7:    step_woff = 7'h0B;
         4'd8:    step_woff = shut ? 7'h26 : 7'h25;
         default: step_woff = 7'h24;
      endcase
   end

   // State register plus every registered bus and config output.
   always_ff @(posedge cpu_clk or negedge cpu_nreset) begin
      if (!cpu_nreset) begin
         state       <= IDLE;
         step        <= 4'd0;
         cnt         <= 4'd0;
         armed       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cpu_a       <= 23'd0;
         cpu_nas     <= 1'b1;
         cpu_nuds    <= 1'b1;
         cpu_nlds    <= 1'b1;
         cpu_rnw     <= 1'b1;
         cpu_d_out   <= 4'd0;
         cpu_d_oe    <= 1'b0;
         cfg_type    <= 8'd0;
         cfg_product <= 8'd0;
         cfg_manuf   <= 16'd0;
         cfg_valid   <= 1'b0;
         cfg_absent  <= 1'b0;
      end else begin
         state       <= state_nxt;
         step        <= step_nxt;
         cnt         <= cnt_nxt;
         armed       <= 1'b1;
         busy        <= busy_nxt;
         done        <= done_nxt;
         cpu_a       <= cpu_a_nxt;
         cpu_nas     <= nas_nxt;
         cpu_nuds    <= nuds_nxt;
         cpu_nlds    <= nlds_nxt;
         cpu_rnw     <= rnw_nxt;
         cpu_d_out   <= d_out_nxt;
         cpu_d_oe    <= d_oe_nxt;
         cfg_type    <= type_nxt;
         cfg_product <= product_nxt;
         cfg_manuf   <= manuf_nxt;
         cfg_valid   <= valid_nxt;
         cfg_absent  <= absent_nxt;
      end
   end

   // Next-state and next-output logic; everything holds unless a state moves it.
   always_comb begin
      state_nxt   = state;
      step_nxt    = step;
      cnt_nxt     = cnt;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      cpu_a_nxt   = cpu_a;
      nas_nxt     = cpu_nas;
      nuds_nxt    = cpu_nuds;
      nlds_nxt    = cpu_nlds;
      rnw_nxt     = cpu_rnw;
      d_out_nxt   = cpu_d_out;
      d_oe_nxt    = cpu_d_oe;
      type_nxt    = cfg_type;
      product_nxt = cfg_product;
      manuf_nxt   = cfg_manuf;
      valid_nxt   = cfg_valid;
      absent_nxt  = cfg_absent;

      case (state)
         IDLE: begin
            // armed delays the first accepted start to the second edge after
            // reset; a start coinciding with done is dropped.
            if (start && armed && !done) begin
               state_nxt = SETUP;
               step_nxt  = 4'd0;
               busy_nxt  = 1'b1;
            end
         end

         SETUP: begin
            cpu_a_nxt = {8'hE8, 8'h00, step_woff};
            rnw_nxt   = !step_write;
            if (step_write) begin
               d_out_nxt = step_wdata;
               d_oe_nxt  = 1'b1;
            end
            state_nxt = STROBE;
         end

         STROBE: begin
            nas_nxt = 1'b0;
            if (!step_write) begin
               nuds_nxt = 1'b0;
               nlds_nxt = 1'b0;
            end
            cnt_nxt   = 4'd0;
            state_nxt = HOLD;
         end

         HOLD: begin
            cnt_nxt = cnt + 4'd1;
            if (step_write) begin
               nuds_nxt = 1'b0;
               if (cnt == WRITE_LAST) state_nxt = RELEASE;
            end else if (cnt == READ_LAST) begin
               state_nxt = RELEASE;
               case (step)
                  4'd0:    type_nxt[7:4]     = cpu_d_in;
                  4'd1:    type_nxt[3:0]     = cpu_d_in;
                  4'd2:    product_nxt[7:4]  = ~cpu_d_in;
                  4'd3:    product_nxt[3:0]  = ~cpu_d_in;
                  4'd4:    manuf_nxt[15:12]  = ~cpu_d_in;
                  4'd5:    manuf_nxt[11:8]   = ~cpu_d_in;
                  4'd6:    manuf_nxt[7:4]    = ~cpu_d_in;
                  4'd7:    manuf_nxt[3:0]    = ~cpu_d_in;
                  default: ;
               endcase
            end
         end

         RELEASE: begin
            nas_nxt   = 1'b1;
            nuds_nxt  = 1'b1;
            nlds_nxt  = 1'b1;
            state_nxt = GAP;
         end

         GAP: begin
            d_oe_nxt = 1'b0;
            if ((step == 4'd1) && (cfg_type == 8'hFF)) begin
               // Floating bus on both type nibbles: nothing in the slot.
               absent_nxt = 1'b1;
               valid_nxt  = 1'b0;
               state_nxt  = IDLE;
               busy_nxt   = 1'b0;
               done_nxt   = 1'b1;
               rnw_nxt    = 1'b1;
            end else if (last_step) begin
               valid_nxt  = !shut;
               absent_nxt = 1'b0;
               state_nxt  = IDLE;
               busy_nxt   = 1'b0;
               done_nxt   = 1'b1;
               rnw_nxt    = 1'b1;
            end else begin
               step_nxt  = step + 4'd1;
               state_nxt = SETUP;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_autoconfig_master.sv
// tb/tb_autoconfig_master.sv - self-checking bench for autoconfig_master

module tb_autoconfig_master;

   localparam int         W  = 4;
   localparam logic [7:0] BH = 8'h20;

   logic        cpu_clk = 1'b0;
   logic        cpu_nreset = 1'b0;
   logic        start = 1'b0;
   logic        busy, done;
   logic [22:0] cpu_a;
   logic        cpu_nas, cpu_nuds, cpu_nlds, cpu_rnw;
   logic [3:0]  cpu_d_out;
   logic        cpu_d_oe;
   logic [3:0]  cpu_d_in;
   logic [7:0]  cfg_type, cfg_product;
   logic [15:0] cfg_manuf;
   logic        cfg_valid, cfg_absent;

   always #5 cpu_clk = ~cpu_clk;

   autoconfig_master #(.WAIT_CLKS(W), .BASE_HI(BH)) dut (
      .cpu_clk(cpu_clk), .cpu_nreset(cpu_nreset), .start(start),
      .busy(busy), .done(done), .cpu_a(cpu_a),
      .cpu_nas(cpu_nas), .cpu_nuds(cpu_nuds), .cpu_nlds(cpu_nlds), .cpu_rnw(cpu_rnw),
      .cpu_d_out(cpu_d_out), .cpu_d_oe(cpu_d_oe), .cpu_d_in(cpu_d_in),
      .cfg_type(cfg_type), .cfg_product(cfg_product), .cfg_manuf(cfg_manuf),
      .cfg_valid(cfg_valid), .cfg_absent(cfg_absent)
   );

   // Responder: one nibble per word offset in the $E80000 window.
   logic [3:0] resp [0:127];
   logic       present = 1'b1;
   always_comb cpu_d_in = present ? resp[cpu_a[6:0]] : 4'hF;

   typedef struct {
      logic [22:0] a;
      logic        rnw;
      logic [3:0]  d;
   } bus_t;

   bus_t exp_q[$];
   bus_t mon_e;

   int checks = 0;
   int errors = 0;

   // Model state: what cfg_* must show while idle, and after the pending run.
   logic [7:0]  cur_type, cur_product, fin_type, fin_product;
   logic [15:0] cur_manuf, fin_manuf;
   logic        cur_valid, cur_absent, fin_valid, fin_absent;

   // Monitor state.
   int          cyc_count = 0;
   int          nas_low_total = 0;
   bit          in_cyc = 0;
   bit          had_prev = 0;
   int          gap = 0;
   int          nas_len, uds_len, lds_len, uds_delay;
   logic [22:0] c_a, p_a, last_wa;
   logic        c_rnw, c_oe, p_rnw;
   logic [3:0]  c_d, last_wd;
   logic [2:0]  p_strb;
   bit          prev_rst = 0;
   bit          prev_done = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [3:0] nib(input int w);
      return present ? resp[w] : 4'hF;
   endfunction

   task automatic push_cycle(input logic [6:0] w, input logic rnw, input logic [3:0] d);
      bus_t e;
      e.a   = {8'hE8, 8'h00, w};
      e.rnw = rnw;
      e.d   = d;
      exp_q.push_back(e);
   endtask

   // Derive the expected bus cycles and final cfg from the responder contents.
   task automatic build_expect();
      int         woff [8] = '{0, 1, 2, 3, 8, 9, 10, 11};
      logic [7:0] t;
      logic [7:0] bh;
      logic       sh;
      bh = BH;
      exp_q.delete();
      fin_type = cur_type; fin_product = cur_product; fin_manuf = cur_manuf;
      fin_valid = cur_valid; fin_absent = cur_absent;
      for (int i = 0; i < 2; i++) push_cycle(7'(woff[i]), 1'b1, 4'h0);
      t = {nib(0), nib(1)};
      fin_type = t;
      if (nib(0) == 4'hF && nib(1) == 4'hF) begin
         fin_valid = 1'b0; fin_absent = 1'b1;
      end else begin
         for (int i = 2; i < 8; i++) push_cycle(7'(woff[i]), 1'b1, 4'h0);
         fin_product = ~{nib(2), nib(3)};
         fin_manuf   = ~{nib(8), nib(9), nib(10), nib(11)};
         sh = 1'b0;
`ifdef AUTOCONFIG_SHUTUP_EN
         sh = (t[2:0] == 3'b000);
`endif
         if (sh) begin
            push_cycle(7'h26, 1'b0, 4'h0);
            fin_valid = 1'b0; fin_absent = 1'b0;
         end else begin
            push_cycle(7'h25, 1'b0, bh[3:0]);
            push_cycle(7'h24, 1'b0, bh[7:4]);
            fin_valid = 1'b1; fin_absent = 1'b0;
         end
      end
   endtask

   task automatic set_resp(input logic [31:0] v);
      int woff [8] = '{0, 1, 2, 3, 8, 9, 10, 11};
      for (int i = 0; i < 8; i++) resp[woff[i]] = v[31-4*i -: 4];
   endtask

   // Compare process: cfg outputs against the model every idle cycle, protocol
   // rules every cycle, and each completed bus cycle against the expected queue.
   always @(negedge cpu_clk) begin
      if (!cpu_nreset) begin
         in_cyc = 0; had_prev = 0; exp_q.delete();
         cur_type = 8'h00; cur_product = 8'h00; cur_manuf = 16'h0000;
         cur_valid = 1'b0; cur_absent = 1'b0;
      end else begin
         if (prev_rst && (cpu_a !== p_a || cpu_rnw !== p_rnw))
            chk("strobes_vs_addr", 32'({cpu_nas, cpu_nuds, cpu_nlds}), 32'(p_strb));
         if (prev_done) chk("done_width", 32'(done), 0);
         if (done) begin
            cur_type = fin_type; cur_product = fin_product; cur_manuf = fin_manuf;
            cur_valid = fin_valid; cur_absent = fin_absent;
         end
         if (!busy) begin
            chk("cfg_type", 32'(cfg_type), 32'(cur_type));
            chk("cfg_product", 32'(cfg_product), 32'(cur_product));
            chk("cfg_manuf", 32'(cfg_manuf), 32'(cur_manuf));
            chk("cfg_valid", 32'(cfg_valid), 32'(cur_valid));
            chk("cfg_absent", 32'(cfg_absent), 32'(cur_absent));
         end
         if (!in_cyc) begin
            if (!cpu_nas) begin
               in_cyc = 1; c_a = cpu_a; c_rnw = cpu_rnw; c_d = cpu_d_out; c_oe = cpu_d_oe;
               nas_len = 1; nas_low_total++;
               uds_len = cpu_nuds ? 0 : 1;
               lds_len = cpu_nlds ? 0 : 1;
               uds_delay = cpu_nuds ? -1 : 0;
               if (had_prev) chk("nas_gap_ge2", 32'(gap >= 2), 1);
            end else begin
               gap++;
            end
         end else if (!cpu_nas) begin
            nas_len++; nas_low_total++;
            if (!cpu_nuds) begin
               uds_len++;
               if (uds_delay < 0) uds_delay = nas_len - 1;
            end
            if (!cpu_nlds) lds_len++;
         end else begin
            in_cyc = 0; had_prev = 1; gap = 1; cyc_count++;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_cycle actual a=%h rnw=%b required none", c_a, c_rnw);
            end else begin
               mon_e = exp_q.pop_front();
               chk("cyc_addr", 32'(c_a), 32'(mon_e.a));
               chk("cyc_rnw", 32'(c_rnw), 32'(mon_e.rnw));
               if (!mon_e.rnw) begin
                  chk("wr_data", 32'(c_d), 32'(mon_e.d));
                  chk("wr_oe", 32'(c_oe), 1);
                  chk("wr_oe_hold", 32'(cpu_d_oe), 1);
                  chk("wr_uds_delay", uds_delay, 1);
                  chk("wr_nas_len", nas_len, W + 1);
                  chk("wr_uds_len", uds_len, W);
                  chk("wr_lds_len", lds_len, 0);
                  last_wa = c_a; last_wd = c_d;
               end else begin
                  chk("rd_nas_len", nas_len, W);
                  chk("rd_uds_delay", uds_delay, 0);
                  chk("rd_uds_len", uds_len, W);
                  chk("rd_lds_len", lds_len, W);
               end
            end
         end
      end
      p_a = cpu_a; p_rnw = cpu_rnw; p_strb = {cpu_nas, cpu_nuds, cpu_nlds};
      prev_rst = cpu_nreset; prev_done = done;
   end

   task automatic pulse_start();
      @(posedge cpu_clk); #1 start = 1'b1;
      @(posedge cpu_clk); #1 start = 1'b0;
   endtask

   // Wait for done; optionally offer a start in the same clock as done.
   task automatic wait_done(input bit poke);
      int n = 0;
      bit seen = 0;
      while (n < 1000 && !seen) begin
         @(negedge cpu_clk); #1;
         n++;
         if (done) seen = 1;
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL done_timeout actual=0 required=1");
      end
      if (poke && seen) begin
         start = 1'b1;
         @(posedge cpu_clk); #1 start = 1'b0;
         chk("start_at_done_dropped", 32'(busy), 0);
      end
   endtask

   int base;
   int nbase;

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 128; i++) resp[i] = 4'h0;
      set_resp(32'hE6EE_EEEE);
      repeat (3) @(posedge cpu_clk);
      #1;
      chk("rst_strobes", 32'({cpu_nas, cpu_nuds, cpu_nlds, cpu_rnw}), 32'hF);
      chk("rst_oe_a_d", 32'({cpu_d_oe, cpu_a, cpu_d_out}), 0);
      chk("rst_busy_done", 32'({busy, done}), 0);
      chk("rst_cfg", 32'({cfg_type, cfg_product, cfg_manuf, cfg_valid, cfg_absent} != 0), 0);

      // Run 1: start held across the first two edges after reset release.
      @(negedge cpu_clk); #1 cpu_nreset = 1'b1;
      build_expect();
      base = cyc_count;
      start = 1'b1;
      @(posedge cpu_clk); #1 chk("start_edge1_ignored", 32'(busy), 0);
      @(posedge cpu_clk); #1 chk("start_edge2_taken", 32'(busy), 1);
      start = 1'b0;
      wait_done(1);
      chk("r1_cycles", cyc_count - base, 10);
      chk("r1_type", 32'(cfg_type), 32'hE6);
      chk("r1_product", 32'(cfg_product), 32'h11);
      chk("r1_manuf", 32'(cfg_manuf), 32'h1111);
      chk("r1_valid", 32'(cfg_valid), 1);
      chk("r1_last_wa", 32'(last_wa), 32'h740024);
      chk("r1_last_wd", 32'(last_wd), 32'h2);
      base = cyc_count;
      repeat (20) @(posedge cpu_clk);
      #1 chk("r1_no_extra_run", cyc_count - base, 0);

      // Run 2: empty slot.
      present = 1'b0;
      build_expect(); base = cyc_count;
      pulse_start(); wait_done(0);
      chk("r2_cycles", cyc_count - base, 2);
      chk("r2_absent", 32'({cfg_absent, cfg_valid}), 32'h2);
      chk("r2_type", 32'(cfg_type), 32'hFF);
      chk("r2_product_held", 32'(cfg_product), 32'h11);
      present = 1'b1;

      // Run 3: distinct nibbles.
      set_resp(32'h1234_5AC0);
      build_expect(); base = cyc_count;
      pulse_start(); wait_done(0);
      chk("r3_cycles", cyc_count - base, 10);
      chk("r3_cfg", 32'({cfg_type, cfg_product, cfg_manuf} == 32'h12CB_A53F), 1);

      // Run 4: only the high type nibble floats high -> still a board.
      set_resp(32'hFE77_7777);
      build_expect(); base = cyc_count;
      pulse_start(); wait_done(0);
      chk("r4_cycles", cyc_count - base, 10);
      chk("r4_cfg", 32'({cfg_type, cfg_product, cfg_manuf} == 32'hFE88_8888), 1);

      // Run 5: 8MB size code.
      set_resp(32'hE8EE_EEEE);
      build_expect(); base = cyc_count;
      pulse_start(); wait_done(0);
`ifdef AUTOCONFIG_SHUTUP_EN
      chk("r5_cycles", cyc_count - base, 9);
      chk("r5_valid", 32'(cfg_valid), 0);
      chk("r5_last_wa", 32'(last_wa), 32'h740026);
      chk("r5_last_wd", 32'(last_wd), 0);
`else
      chk("r5_cycles", cyc_count - base, 10);
      chk("r5_valid", 32'(cfg_valid), 1);
`endif

      // Run 6: second start in the middle of a run.
      set_resp(32'hE6EE_EEEE);
      build_expect(); base = cyc_count;
      pulse_start();
      repeat (15) @(posedge cpu_clk);
      pulse_start();
      wait_done(0);
      chk("r6_cycles", cyc_count - base, 10);

      // Run 7: reset in the middle of the $48 write.
      build_expect();
      pulse_start();
      begin
         int n = 0;
         bit hit = 0;
         while (n < 1000 && !hit) begin
            @(negedge cpu_clk); #1;
            n++;
            if (!cpu_nas && cpu_a == 23'h740024) hit = 1;
         end
         chk("r7_saw_48_write", 32'(hit), 1);
      end
      @(posedge cpu_clk); #2 cpu_nreset = 1'b0;
      #1;
      chk("r7_rst_strobes", 32'({cpu_nas, cpu_nuds, cpu_nlds}), 32'h7);
      chk("r7_rst_busy_oe", 32'({busy, cpu_d_oe}), 0);
      nbase = nas_low_total;
      #10 cpu_nreset = 1'b1;
      repeat (30) @(posedge cpu_clk);
      #1;
      chk("r7_quiet_after_rst", nas_low_total - nbase, 0);
      chk("r7_idle_after_rst", 32'({busy, cpu_nas}), 1);

      // Run 8: normal run after the reset, starting from cleared cfg.
      build_expect(); base = cyc_count;
      pulse_start(); wait_done(0);
      chk("r8_cycles", cyc_count - base, 10);
      chk("r8_valid", 32'(cfg_valid), 1);

      repeat (3) @(posedge cpu_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/autoconfig_master.md
AUTOCONFIG_MASTER -- requirements
Module: autoconfig_master

Interface
REQ-001 Parameter WAIT_CLKS, default 4: cpu_clk cycles the strobes stay asserted before read data is sampled or a write ends (legal range 2..15).
REQ-002 Parameter BASE_HI, default 8'h20: base address bits A23..A16 written to the board (8'h20 = $200000).
REQ-003 cpu_clk  in  1  bus clock; all state advances on its rising edge.
REQ-004 cpu_nreset  in  1  system reset, asynchronous, active-low.
REQ-005 start  in  1  one-clock pulse that begins a probe/configure run; ignored while busy=1.
REQ-006 busy  out  1  high from the clock after an accepted start until the run ends.
REQ-007 done  out  1  one-clock pulse when a run ends.
REQ-008 cpu_a  out  23  address A23..A1.
REQ-009 cpu_nas, cpu_nuds, cpu_nlds  out  1 each  68000 address strobe and data strobes, active-low.
REQ-010 cpu_rnw  out  1  1 = read, 0 = write.
REQ-011 cpu_d_out  out  4  write data on D15..D12.
REQ-012 cpu_d_oe  out  1  drive enable for cpu_d_out.
REQ-013 cpu_d_in  in  4  read data from D15..D12.
REQ-014 cfg_type  out  8  er_Type, raw nibbles from $00 (high) and $02 (low).
REQ-015 cfg_product  out  8  product number: $04 and $06 nibbles, each inverted.
REQ-016 cfg_manuf  out  16  manufacturer: $10, $12, $14, $16 nibbles, each inverted, $10 most significant.
REQ-017 cfg_valid  out  1  high when the last run configured a board.
REQ-018 cfg_absent  out  1  high when the last run found no board.

Function
REQ-019 Read sequence: $E80000, $E80002, $E80004, $E80006, $E80010, $E80012, $E80014, $E80016.
REQ-020 Each read cycle:
  - clock 1: set cpu_a and cpu_rnw=1; strobes stay high.
  - clock 2: drive cpu_nas, cpu_nuds and cpu_nlds low together.
  - hold strobes low for WAIT_CLKS clocks.
  - sample cpu_d_in on the last of those clocks.
  - next clock: release all strobes high.
REQ-021 Each write cycle:
  - clock 1: set cpu_a, cpu_d_out, cpu_d_oe=1 and cpu_rnw=0.
  - clock 2: drive cpu_nas low.
  - clock 3: drive cpu_nuds low; cpu_nlds stays high.
  - hold cpu_nuds low for WAIT_CLKS clocks.
  - then release all strobes; cpu_d_oe drops one clock later.
REQ-022 cpu_nas stays high for at least 2 rising edges between consecutive cycles.
REQ-023 Absent detect: after the $02 read, if the raw $00 and $02 nibbles are both 4'hF:
  - set cfg_absent=1 and cfg_valid=0;
  - skip all remaining reads and writes;
  - pulse done.
REQ-024 When a board is present, after the eighth read:
  - write BASE_HI[3:0] to $E8004A;
  - then write BASE_HI[7:4] to $E80048;
  - then set cfg_valid=1 and cfg_absent=0, and pulse done.
REQ-025 FSM states:
  - IDLE -> SETUP -> STROBE -> HOLD -> RELEASE -> GAP;
  - GAP returns to SETUP for the next cycle, or to IDLE when the sequence is complete.
  - A 4-bit step index selects the address, direction and data for each cycle.
REQ-026 cfg_* outputs are updated only as the nibbles are sampled, and hold their values between runs.
REQ-027 A start pulse while busy=1 is dropped. A start pulse in the same clock as done is also dropped.
REQ-028 Strobes never change in the same clock that cpu_a or cpu_rnw change.

Reset
REQ-029 On cpu_nreset low, immediately:
  - FSM to IDLE;
  - cpu_nas, cpu_nuds, cpu_nlds = 1; cpu_rnw = 1;
  - cpu_d_oe = 0; cpu_a = 0; cpu_d_out = 0;
  - busy = 0; done = 0; cfg_* = 0.
REQ-030 A reset in the middle of a cycle releases the strobes at once. No partial write may complete after reset deasserts.
REQ-031 The first start is accepted on the second rising edge after cpu_nreset goes high.

Configuration
REQ-032 Macro AUTOCONFIG_SHUTUP_EN:
  - when defined: if size code cfg_type[2:0] = 3'b000 (8MB), replace both base writes with a single write of 4'h0 to $E8004C, and report cfg_valid=0, cfg_absent=0;
  - when not defined: the size code is ignored and the board is always given the base address.

Verification
REQ-033 Responder returns $00=E, $02=6, $04=E, $06=E, $10..$16=E; start pulse -> the following, then done pulse:
  - cfg_type=8'hE6, cfg_product=8'h11, cfg_manuf=16'h1111;
  - writes $4A<-0, then $48<-2;
  - cfg_valid=1.
REQ-034 No responder (bus reads 4'hF) -> exactly 2 read cycles; cfg_absent=1; no write cycle seen.
REQ-035 WAIT_CLKS=4 -> each read holds cpu_nas low exactly 4 clocks; cpu_nas is high for at least 2 clocks between cycles; a write's cpu_nuds falls 1 clock after cpu_nas.
REQ-036 cpu_nreset pulsed low during the $48 write -> strobes high within the same clock; busy=0; no further bus activity until the next start.
REQ-037 With AUTOCONFIG_SHUTUP_EN defined, $02=8 (size 000) -> a single write of 0 to $E8004C; cfg_valid=0.
REQ-038 Second start pulse during a run -> ignored; exactly 10 bus cycles in total.
